// File: rtl/sweep_sequencer.sv
// Burst slot scheduler for the AD9914 strobes: each slot opens with an update or
// pre-trigger strobe, waits a lead-in, fires trig_1, then idles out to the slot length.
module sweep_sequencer #(
   parameter int UPD_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] pri,
   input  logic [15:0] pre_lead,
   input  logic [31:0] trig_len,
   input  logic [15:0] n_pulses,
   input  logic [7:0]  ct_div,
   output logic        ad9914_update_1,
   output logic        ad9914_pre_trig_1,
   output logic        ad9914_update_2,
   output logic        ad9914_trig_1,
   output logic        busy,
   output logic        done,
   output logic        cfg_err,
   output logic [15:0] pulse_idx
);

   typedef enum logic [1:0] {IDLE, LEAD, TRIG, TAIL} state_t;

   state_t      r_state;
   logic [31:0] r_sc;
   logic [7:0]  r_ct;
   logic        r_first;
   logic        r_stop_pend;
   logic [31:0] r_lead_end;
   logic [31:0] r_trig_end;
   logic [31:0] r_pri_end;
   logic [15:0] r_n_last;
   logic        r_n_cont;
   logic [7:0]  r_ct_div;

   state_t      w_state_next;
   logic [31:0] w_sc_next;
   logic [15:0] w_pidx_next;
   logic [7:0]  w_ct_next;
   logic        w_first_next;
   logic        w_stop_pend_next;
   logic        w_done_next;
   logic        w_cfg_err_next;
   logic        w_load;
   logic        w_cfg_ok;
   logic        w_last_slot;
   logic [7:0]  w_ct_div_next;
   logic        w_strobe;

   // Widened so a huge pre_lead + trig_len cannot wrap past pri.
   assign w_cfg_ok = ({16'd0, pre_lead} >= 32'(UPD_W)) && (trig_len != 32'd0) &&
                     ({2'b00, pri} >= ({18'd0, pre_lead} + {2'b00, trig_len} + 34'd1));

   assign w_last_slot = r_stop_pend || stop || (!r_n_cont && (pulse_idx == r_n_last));

   always_comb begin
      w_state_next     = r_state;
      w_sc_next        = r_sc;
      w_pidx_next      = pulse_idx;
      w_ct_next        = r_ct;
      w_first_next     = r_first;
      w_stop_pend_next = r_stop_pend;
      w_done_next      = 1'b0;
      w_cfg_err_next   = cfg_err;
      w_load           = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_cfg_ok) begin
                  w_load           = 1'b1;
                  w_state_next     = LEAD;
                  w_sc_next        = 32'd0;
                  w_pidx_next      = 16'd0;
                  w_ct_next        = 8'd0;
                  w_first_next     = 1'b1;
                  w_stop_pend_next = 1'b0;
                  w_cfg_err_next   = 1'b0;
               end else begin
                  w_cfg_err_next = 1'b1;
               end
            end
         end
         default: begin
            if (stop) w_stop_pend_next = 1'b1;
            w_sc_next = r_sc + 32'd1;
            case (r_state)
               LEAD: if (r_sc == r_lead_end) w_state_next = TRIG;
               TRIG: if (r_sc == r_trig_end) w_state_next = TAIL;
               TAIL: begin
                  if (r_sc == r_pri_end) begin
                     w_pidx_next  = pulse_idx + 16'd1;
                     w_ct_next    = ((r_ct_div == 8'd0) || (r_ct == r_ct_div - 8'd1)) ?
                                    8'd0 : r_ct + 8'd1;
                     w_first_next = 1'b0;
                     w_sc_next    = 32'd0;
                     if (w_last_slot) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                     end else begin
                        w_state_next = LEAD;
                     end
                  end
               end
               default: w_state_next = IDLE;
            endcase
         end
      endcase
   end

   // Outputs are decoded from next-state values so they line up with the slot counter.
   assign w_ct_div_next = w_load ? ct_div : r_ct_div;
   assign w_strobe      = (w_state_next != IDLE) && (w_sc_next < 32'(UPD_W));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state           <= IDLE;
         r_sc              <= 32'd0;
         r_ct              <= 8'd0;
         r_first           <= 1'b0;
         r_stop_pend       <= 1'b0;
         r_lead_end        <= 32'd0;
         r_trig_end        <= 32'd0;
         r_pri_end         <= 32'd0;
         r_n_last          <= 16'd0;
         r_n_cont          <= 1'b0;
         r_ct_div          <= 8'd0;
         pulse_idx         <= 16'd0;
         cfg_err           <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         ad9914_update_1   <= 1'b0;
         ad9914_pre_trig_1 <= 1'b0;
         ad9914_update_2   <= 1'b0;
         ad9914_trig_1     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sc        <= w_sc_next;
         r_ct        <= w_ct_next;
         r_first     <= w_first_next;
         r_stop_pend <= w_stop_pend_next;
         pulse_idx   <= w_pidx_next;
         cfg_err     <= w_cfg_err_next;
         if (w_load) begin
            r_lead_end <= {16'd0, pre_lead} - 32'd1;
            r_trig_end <= {16'd0, pre_lead} + trig_len - 32'd1;
            r_pri_end  <= pri - 32'd1;
            r_n_last   <= n_pulses - 16'd1;
            r_n_cont   <= (n_pulses == 16'd0);
            r_ct_div   <= ct_div;
         end
         busy              <= (w_state_next != IDLE);
         done              <= w_done_next;
         ad9914_update_1   <= w_strobe && w_first_next;
         ad9914_pre_trig_1 <= w_strobe && !w_first_next;
         ad9914_update_2   <= w_strobe && (w_ct_div_next != 8'd0) && (w_ct_next == 8'd0);
         ad9914_trig_1     <= (w_state_next == TRIG);
      end
   end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: per-cycle expected strobes from slot arithmetic.
module tb_sweep_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [31:0] pri;
   logic [15:0] pre_lead;
   logic [31:0] trig_len;
   logic [15:0] n_pulses;
   logic [7:0]  ct_div;
   logic        ad9914_update_1;
   logic        ad9914_pre_trig_1;
   logic        ad9914_update_2;
   logic        ad9914_trig_1;
   logic        busy;
   logic        done;
   logic        cfg_err;
   logic [15:0] pulse_idx;

   int n_vec  = 0;
   int n_fail = 0;

   sweep_sequencer #(.UPD_W(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .stop              (stop),
      .pri               (pri),
      .pre_lead          (pre_lead),
      .trig_len          (trig_len),
      .n_pulses          (n_pulses),
      .ct_div            (ct_div),
      .ad9914_update_1   (ad9914_update_1),
      .ad9914_pre_trig_1 (ad9914_pre_trig_1),
      .ad9914_update_2   (ad9914_update_2),
      .ad9914_trig_1     (ad9914_trig_1),
      .busy              (busy),
      .done              (done),
      .cfg_err           (cfg_err),
      .pulse_idx         (pulse_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {26'd0, busy, done, ad9914_update_1, ad9914_pre_trig_1, ad9914_update_2, ad9914_trig_1};
   endfunction

   // Expected: {busy,done,update_1,pre_trig_1,update_2,trig_1} for 1-based cycle k after start edge.
   task automatic burst(input int P, input int L, input int T, input int NP, input int D,
                        input int NS, input int NCYC, input int POKE, input int STOPK);
      int s, off;
      logic [31:0] e_outs, e_pidx;
      pri      = 32'(P);
      pre_lead = 16'(L);
      trig_len = 32'(T);
      n_pulses = 16'(NP);
      ct_div   = 8'(D);
      start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= NCYC; k++) begin
         @(negedge clk);
         s = (k - 1) / P;
         off = (k - 1) % P;
         if (s < NS) begin
            e_outs = {26'd0, 1'b1, 1'b0, (s == 0) && (off < 4), (s > 0) && (off < 4),
                      (D != 0) && ((s % ((D == 0) ? 1 : D)) == 0) && (off < 4),
                      (off >= L) && (off < L + T)};
            e_pidx = 32'(s);
         end else begin
            e_outs = {26'd0, 1'b0, (k == NS * P + 1), 4'b0000};
            e_pidx = 32'(NS);
         end
         check("outs", k, outs(), e_outs);
         check("pulse_idx", k, {16'd0, pulse_idx}, e_pidx);
         if (k == 1) begin
            start = 1'b0;
            check("cfg_err_clear", k, {31'd0, cfg_err}, 32'd0);
         end
         stop = (k == STOPK);
         if (k == POKE) begin
            start    = 1'b1;
            pri      = 32'd7;
            pre_lead = 16'd1;
            trig_len = 32'd1;
            n_pulses = 16'd1;
            ct_div   = 8'd1;
         end else if (k == POKE + 1) begin
            start = 1'b0;
         end
      end
      stop  = 1'b0;
      start = 1'b0;
   endtask

   task automatic reject(input int P, input int L, input int T);
      pri      = 32'(P);
      pre_lead = 16'(L);
      trig_len = 32'(T);
      n_pulses = 16'd2;
      ct_div   = 8'd1;
      start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         check("reject_cfg_err", k, {31'd0, cfg_err}, 32'd1);
         check("reject_outs", k, outs(), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      pri = 32'd0; pre_lead = 16'd0; trig_len = 32'd0; n_pulses = 16'd0; ct_div = 8'd0;
      #12;
      check("reset_outs", 0, outs(), 32'd0);
      check("reset_cfg_err", 0, {31'd0, cfg_err}, 32'd0);
      check("reset_pidx", 0, {16'd0, pulse_idx}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // stop while idle must do nothing
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("idle_stop_outs", 0, outs(), 32'd0);
      @(negedge clk);
      check("idle_stop_outs2", 0, outs(), 32'd0);

      // basic burst, with a start and config scramble mid-burst
      burst(100, 10, 20, 3, 0, 3, 310, 50, 0);
      // CT cadence every 2nd slot
      burst(100, 10, 20, 5, 2, 5, 505, 0, 0);
      // continuous, stop during slot-3 trigger
      burst(100, 10, 20, 0, 0, 4, 410, 0, 315);
      // continuous, stop in final cycle of slot 1
      burst(100, 10, 20, 0, 0, 2, 210, 0, 200);
      // stop coinciding with natural end
      burst(100, 10, 20, 2, 0, 2, 230, 0, 200);

      // config rejections then a boundary-valid start
      reject(30, 10, 20);
      reject(100, 3, 20);
      reject(100, 10, 0);
      burst(31, 10, 20, 2, 1, 2, 70, 0, 0);
      burst(26, 4, 1, 3, 3, 3, 85, 0, 0);

      // reset mid-burst while trig_1 is high
      burst(100, 10, 20, 0, 0, 99, 15, 0, 0);
      #2 rst = 1'b0;
      #1;
      check("async_rst_outs", 0, outs(), 32'd0);
      check("async_rst_pidx", 0, {16'd0, pulse_idx}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("in_rst_outs", k, outs(), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_outs", 0, outs(), 32'd0);
      burst(40, 6, 8, 2, 1, 2, 90, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Generates the AD9914 control strobes (update_1, update_2, pre_trig_1, trig_1) that drive the transmit/CT work flow. It is a programmable pulse-repetition scheduler that divides a burst into fixed-length slots, and it sits between the host configuration registers and the TR/TV/CT sequencing logic. Each slot opens with a profile-update strobe, followed by a lead-in delay and a trigger pulse. Every Nth slot additionally requests a CT sweep.

## Interface
Parameters:
- UPD_W, 4, width in clk cycles of update_1 / update_2 / pre_trig_1 strobes (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to start a burst (IDLE only)
- stop  in  1  single-cycle request to end the burst at the end of the current slot
- pri  in  32  slot length in cycles
- pre_lead  in  16  cycles from slot start to trig_1 rise
- trig_len  in  32  trig_1 high time in cycles
- n_pulses  in  16  slots per burst; 0 = continuous until stop
- ct_div  in  8  CT request every ct_div slots; 0 = never
- ad9914_update_1  out  1  profile-update strobe, slot 0 only
- ad9914_pre_trig_1  out  1  pre-trigger strobe, slots ≥1
- ad9914_update_2  out  1  CT-sweep start strobe
- ad9914_trig_1  out  1  trigger pulse
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- cfg_err  out  1  last start rejected (sticky until next accepted start)
- pulse_idx  out  16  index of current slot

## Operation
- States: IDLE, LEAD, TRIG, TAIL.
- IDLE + start: configuration is validated. The rule is pre_lead ≥ UPD_W and trig_len ≥ 1 and pri ≥ pre_lead+trig_len+1.
  - Invalid: cfg_err ← 1; stay IDLE.
  - Valid: latch all config inputs into shadow registers; cfg_err ← 0; pulse_idx ← 0; slot counter sc ← 0; ct counter ← 0; stop_pend ← 0; go LEAD.
- Config inputs are ignored except in the start cycle.
- Slot timing uses sc, which counts 0..pri−1 within each slot:
  - sc < UPD_W: strobe high. Slot 0 drives update_1; later slots drive pre_trig_1.
  - CT request: if ct_div≠0 and the ct counter = 0, update_2 is high over the same cycles.
  - LEAD→TRIG when sc = pre_lead−1.
  - TRIG: trig_1 high. TRIG→TAIL when sc = pre_lead+trig_len−1.
  - TAIL: slot ends when sc = pri−1.
- Slot end:
  - pulse_idx increments, wrapping 16 bits.
  - ct counter increments and wraps to 0 at ct_div−1.
  - If stop_pend, or (n_pulses≠0 and pulse_idx = n_pulses−1): go IDLE and pulse done.
  - Else: sc ← 0 and go LEAD.
- stop (busy) sets stop_pend. The current slot, including a full trig_1, always completes. stop in IDLE is ignored.
- start while busy is ignored.
- busy = (state ≠ IDLE).

## Timing
- Reset (async, rst=0), immediately:
  - All outputs 0.
  - State IDLE; all counters and cfg_err 0.
- Release is synchronous to clk; the first transition happens on the first edge with rst=1.
- All outputs are registered; no combinational input→output paths.
- start accepted at edge t:
  - busy=1 and the slot-0 strobe from cycle t+1.
  - trig_1 rises at cycle t+1+pre_lead and stays high trig_len cycles.
  - Next slot's pre_trig_1 rises at t+1+pri.
- Burst of N slots: done is high for the single cycle t+1+N·pri, with busy=0 in that same cycle. A new start is accepted in that cycle.
- stop arriving in the final cycle of a slot: that slot is the last.
- stop coinciding with a natural end: a single done, no extra slot.
- Continuous mode (n_pulses=0): pulse_idx wraps 65535→0 without ending the burst.
- Reset mid-burst: strobes and trig_1 drop asynchronously; no done.

## Test plan
- Basic burst: UPD_W=4, pri=100, pre_lead=10, trig_len=20, n_pulses=3, ct_div=0, start at t.
  - update_1 high t+1..t+4.
  - pre_trig_1 high t+101..t+104 and t+201..t+204.
  - trig_1 high t+11..t+30, t+111..t+130, t+211..t+230.
  - done at t+301; update_2 never asserted.
- CT cadence: same config with n_pulses=5, ct_div=2 → update_2 strobes in slots 0, 2 and 4 only, each aligned with that slot's update_1 / pre_trig_1.
- Stop handling: n_pulses=0, stop during the TRIG of slot 3 → trig_1 completes its full 20 cycles; done at slot-3 end; pulse_idx was 3 during the last slot.
- Config rejection: pri=30, pre_lead=10, trig_len=20 → cfg_err=1, busy stays 0, no strobes. A following valid start clears cfg_err.
- Reset mid-burst: rst=0 while trig_1=1 → all outputs 0 without waiting for a clk edge; no done; after release, a new start runs normally from slot 0.
- Ignored inputs: start while busy and stop while IDLE → no effect on timing; config input changes during the burst do not alter slot timing.
